// File: rtl/fft_16_frame_ctrl_if.sv
// Stream, core and status signals of the 16-point FFT frame sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface fft_16_frame_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_real;
  logic [WIDTH-1:0] in_imag;

  logic             core_x_valid;
  logic [WIDTH-1:0] core_x_real;
  logic [WIDTH-1:0] core_x_imag;
  logic             core_y_valid;
  logic [WIDTH-1:0] core_y_real;
  logic [WIDTH-1:0] core_y_imag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_real;
  logic [WIDTH-1:0] out_imag;
  logic             out_last;

  logic             busy;
  logic             err_timeout;
  logic [7:0]       frame_cnt;

  modport master (
    input  in_valid, in_real, in_imag, core_y_valid, core_y_real, core_y_imag, out_ready,
    output in_ready, core_x_valid, core_x_real, core_x_imag, out_valid, out_real, out_imag,
    output out_last, busy, err_timeout, frame_cnt
  );

  modport slave (
    output in_valid, in_real, in_imag, core_y_valid, core_y_real, core_y_imag, out_ready,
    input  in_ready, core_x_valid, core_x_real, core_x_imag, out_valid, out_real, out_imag,
    input  out_last, busy, err_timeout, frame_cnt
  );
endinterface

// File: rtl/fft_16_frame_ctrl.sv
// Frame sequencer for a 16-point FFT core: gathers 16 samples, feeds them to the core,
// captures 16 results, optionally undoes bit-reversed ordering and streams them out.
// A watchdog aborts frames whose results stop arriving.
module fft_16_frame_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 64,
  parameter bit          BITREV  = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  fft_16_frame_ctrl_if.master bus
);
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StFill, StFeed, StWait, StDrain} state_e;

  state_e           state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [3:0]       ycnt_q, ycnt_d;
  logic [3:0]       rcnt_q, rcnt_d;
  logic             cap_done_q, cap_done_d;
  logic [WdW-1:0]   wd_q, wd_d, wd_inc;
  logic             err_q, err_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             core_x_valid_q, core_x_valid_d;
  logic [WIDTH-1:0] core_x_real_q, core_x_real_d;
  logic [WIDTH-1:0] core_x_imag_q, core_x_imag_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out_real_q, out_real_d;
  logic [WIDTH-1:0] out_imag_q, out_imag_d;
  logic [3:0]       rd_idx;

  logic [WIDTH-1:0] ibuf_re [16];
  logic [WIDTH-1:0] ibuf_im [16];
  logic [WIDTH-1:0] obuf_re [16];
  logic [WIDTH-1:0] obuf_im [16];

  logic in_fire, y_fire, out_fire;

  function automatic logic [3:0] rev4(input logic [3:0] i);
    return {i[0], i[1], i[2], i[3]};
  endfunction

  assign in_fire  = bus.in_valid && (state_q == StFill);
  // Results are only taken while a frame is with the core and not yet fully captured.
  assign y_fire   = bus.core_y_valid && !cap_done_q && ((state_q == StFeed) || (state_q == StWait));
  assign out_fire = out_valid_q && bus.out_ready;
  assign wd_inc   = wd_q + WdW'(1);

  // Next-state for the frame FSM, counters, watchdog and status.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    fcnt_d      = fcnt_q;
    ycnt_d      = ycnt_q;
    rcnt_d      = rcnt_q;
    cap_done_d  = cap_done_q;
    wd_d        = '0;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;

    if (y_fire) begin
      ycnt_d = ycnt_q + 4'd1;
      if (ycnt_q == 4'd15) cap_done_d = 1'b1;
    end

    case (state_q)
      StFill: begin
        if (in_fire) begin
          wcnt_d = wcnt_q + 4'd1;
          if (wcnt_q == 4'd15) begin
            state_d = StFeed;
            fcnt_d  = 4'd0;
          end
        end
      end
      StFeed: begin
        fcnt_d = fcnt_q + 4'd1;
        // An early full capture still lets the feed run to completion.
        if (fcnt_q == 4'd15) state_d = cap_done_d ? StDrain : StWait;
      end
      StWait: begin
        if (cap_done_d) begin
          state_d = StDrain;
        end else if (!bus.core_y_valid) begin
          wd_d = wd_inc;
          if (wd_inc == WdW'(TIMEOUT)) begin
            wd_d       = '0;
            err_d      = 1'b1;
            state_d    = StFill;
            wcnt_d     = 4'd0;
            ycnt_d     = 4'd0;
            cap_done_d = 1'b0;
          end
        end
      end
      StDrain: begin
        if (out_fire) begin
          rcnt_d = rcnt_q + 4'd1;
          if (rcnt_q == 4'd15) begin
            state_d     = StFill;
            frame_cnt_d = frame_cnt_q + 8'd1;
            ycnt_d      = 4'd0;
            cap_done_d  = 1'b0;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Registered core and output data, derived from the next state so they align with it.
  always_comb begin
    rd_idx         = BITREV ? rev4(rcnt_d) : rcnt_d;
    core_x_valid_d = (state_d == StFeed);
    core_x_real_d  = core_x_valid_d ? ibuf_re[fcnt_d] : '0;
    core_x_imag_d  = core_x_valid_d ? ibuf_im[fcnt_d] : '0;
    out_valid_d    = (state_d == StDrain);
    out_real_d     = out_valid_d ? obuf_re[rd_idx] : '0;
    out_imag_d     = out_valid_d ? obuf_im[rd_idx] : '0;
    out_last_d     = out_valid_d && (rcnt_d == 4'd15);
  end

  // Sample buffers; contents need no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      ibuf_re[wcnt_q] <= bus.in_real;
      ibuf_im[wcnt_q] <= bus.in_imag;
    end
    if (y_fire) begin
      obuf_re[ycnt_q] <= bus.core_y_real;
      obuf_im[ycnt_q] <= bus.core_y_imag;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StFill;
      wcnt_q         <= '0;
      fcnt_q         <= '0;
      ycnt_q         <= '0;
      rcnt_q         <= '0;
      cap_done_q     <= 1'b0;
      wd_q           <= '0;
      err_q          <= 1'b0;
      frame_cnt_q    <= '0;
      core_x_valid_q <= 1'b0;
      core_x_real_q  <= '0;
      core_x_imag_q  <= '0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      out_real_q     <= '0;
      out_imag_q     <= '0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      fcnt_q         <= fcnt_d;
      ycnt_q         <= ycnt_d;
      rcnt_q         <= rcnt_d;
      cap_done_q     <= cap_done_d;
      wd_q           <= wd_d;
      err_q          <= err_d;
      frame_cnt_q    <= frame_cnt_d;
      core_x_valid_q <= core_x_valid_d;
      core_x_real_q  <= core_x_real_d;
      core_x_imag_q  <= core_x_imag_d;
      out_valid_q    <= out_valid_d;
      out_last_q     <= out_last_d;
      out_real_q     <= out_real_d;
      out_imag_q     <= out_imag_d;
    end
  end

  assign bus.in_ready     = (state_q == StFill);
  assign bus.core_x_valid = core_x_valid_q;
  assign bus.core_x_real  = core_x_real_q;
  assign bus.core_x_imag  = core_x_imag_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_real     = out_real_q;
  assign bus.out_imag     = out_imag_q;
  assign bus.out_last     = out_last_q;
  assign bus.busy         = (state_q != StFill) || (wcnt_q != 4'd0);
  assign bus.err_timeout  = err_q;
  assign bus.frame_cnt    = frame_cnt_q;
endmodule

// File: tb/tb_fft_16_frame_ctrl.sv
// Bench for fft_16_frame_ctrl: two instances (natural and bit-reversed output order) run in
// lockstep against a queue-based core model and a reference of the frame's expected output.
module tb_fft_16_frame_ctrl;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 64;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    int           due;
  } item_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fft_16_frame_ctrl_if #(.WIDTH(W)) bus0 ();
  fft_16_frame_ctrl_if #(.WIDTH(W)) bus1 ();

  fft_16_frame_ctrl #(.WIDTH(W), .TIMEOUT(TO), .BITREV(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  fft_16_frame_ctrl #(.WIDTH(W), .TIMEOUT(TO), .BITREV(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_frames = 0;
  logic exp_err = 1'b0;

  // Core model controls: 0 identity, 1 returns capture index, 2 silent.
  int core_mode = 0;
  int core_lat = 3;
  bit core_gap = 1'b0;
  bit gap_tog = 1'b0;
  int cyc = 0;
  int yc = 0;
  item_t cq[$];

  logic [W-1:0] xr[16];
  logic [W-1:0] xi[16];
  logic [2*W:0] o0[$];
  logic [2*W:0] o1[$];
  logic [W-1:0] cx[$];
  int cx_first, cx_last, stab_viol, rdy_viol;
  bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int rev_tbl[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  function automatic int rev4(input int k);
    int r = 0;
    for (int b = 0; b < 4; b++) if (((k >> b) & 1) != 0) r += 1 << (3 - b);
    return r;
  endfunction

  // Expected k-th output {last, real, imag} for an instance with the given ordering.
  function automatic logic [2*W:0] exp_out(input int brev, input int k);
    int j;
    logic [W-1:0] r, i;
    j = (brev != 0) ? rev4(k) : k;
    if (core_mode == 1) begin
      r = W'(j);
      i = W'(32'hA000 + j);
    end else begin
      r = xr[j];
      i = xi[j];
    end
    return {(k == 15), r, i};
  endfunction

  // Core model: answers core_x samples after core_lat cycles, optionally every other cycle.
  initial begin
    item_t it;
    logic yv;
    logic [W-1:0] yr, yi;
    forever begin
      @(negedge clk);
      yv = 1'b0; yr = '0; yi = '0;
      if (!reset_n) begin
        cq.delete();
        yc = 0;
      end else begin
        if (bus0.core_x_valid && core_mode != 2) begin
          it.re = bus0.core_x_real; it.im = bus0.core_x_imag; it.due = cyc + core_lat;
          cq.push_back(it);
        end
        if (cq.size() > 0 && cq[0].due <= cyc && (!core_gap || gap_tog)) begin
          it = cq.pop_front();
          yv = 1'b1;
          if (core_mode == 1) begin
            yr = W'(yc); yi = W'(32'hA000 + yc); yc = (yc + 1) % 16;
          end else begin
            yr = it.re; yi = it.im;
          end
        end
      end
      bus0.core_y_valid = yv; bus0.core_y_real = yr; bus0.core_y_imag = yi;
      bus1.core_y_valid = yv; bus1.core_y_real = yr; bus1.core_y_imag = yi;
      gap_tog = ~gap_tog;
      cyc++;
    end
  end

  task automatic drive_in(input logic v, input logic [W-1:0] r, input logic [W-1:0] i);
    bus0.in_valid = v; bus0.in_real = r; bus0.in_imag = i;
    bus1.in_valid = v; bus1.in_real = r; bus1.in_imag = i;
  endtask

  task automatic feed_frame(input bit in_gap, output bit ok);
    int sent = 0;
    int n = 0;
    bit tog = 1'b0;
    while (sent < 16 && n < 300) begin
      @(negedge clk);
      n++; tog = ~tog;
      if (in_gap && tog) begin
        drive_in(1'b0, '0, '0);
      end else begin
        drive_in(1'b1, xr[sent], xi[sent]);
        if (bus0.in_ready) sent++;
      end
    end
    ok = (sent == 16);
  endtask

  // Feeds xr/xi, then collects outputs of both instances; stops early when instance 0
  // is presenting sample stop_at (if >= 0).
  task automatic run_frame(input bit in_gap, input int rdy_mode, input int stop_at,
                           output bit done);
    bit ok, r, st0, st1;
    int n, rp;
    logic [2*W:0] p0, p1, c0, c1;
    o0.delete(); o1.delete(); cx.delete();
    cx_first = -1; cx_last = -1; stab_viol = 0; rdy_viol = 0;
    done = 1'b0; st0 = 1'b0; st1 = 1'b0; rp = 0; n = 0; p0 = '0; p1 = '0;
    feed_frame(in_gap, ok);
    if (!ok) return;
    while (n < 800) begin
      @(negedge clk);
      n++;
      drive_in(1'b0, '0, '0);
      if (o0.size() < 16 && bus0.in_ready) rdy_viol++;
      if (o1.size() < 16 && bus1.in_ready) rdy_viol++;
      if (bus0.core_x_valid) begin
        cx.push_back(bus0.core_x_real);
        if (cx_first < 0) cx_first = n;
        cx_last = n;
      end
      c0 = {bus0.out_last, bus0.out_real, bus0.out_imag};
      c1 = {bus1.out_last, bus1.out_real, bus1.out_imag};
      if (st0 && (!bus0.out_valid || c0 !== p0)) stab_viol++;
      if (st1 && (!bus1.out_valid || c1 !== p1)) stab_viol++;
      if (stop_at >= 0 && o0.size() == stop_at && bus0.out_valid) begin
        done = 1'b1;
        return;
      end
      if (o0.size() == 16 && o1.size() == 16) begin
        done = 1'b1;
        return;
      end
      r = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? pat[rp % 6] : 1'($urandom % 2);
      rp++;
      bus0.out_ready = r; bus1.out_ready = r;
      if (bus0.out_valid && r) o0.push_back(c0);
      if (bus1.out_valid && r) o1.push_back(c1);
      st0 = bus0.out_valid && !r; p0 = c0;
      st1 = bus1.out_valid && !r; p1 = c1;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp += 6;
    if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset out_valid got %b/%b want 0", bus0.out_valid, bus1.out_valid);
    end
    if (bus0.core_x_valid !== 1'b0 || bus0.core_x_real !== '0) begin
      n_bad++; $display("FAIL reset core_x got %b/%h want 0/0", bus0.core_x_valid, bus0.core_x_real);
    end
    if (bus0.out_real !== '0 || bus0.out_last !== 1'b0) begin
      n_bad++; $display("FAIL reset out data got %h/%b want 0", bus0.out_real, bus0.out_last);
    end
    if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0) begin
      n_bad++; $display("FAIL reset busy got %b/%b want 0", bus0.busy, bus1.busy);
    end
    if (bus0.err_timeout !== 1'b0) begin
      n_bad++; $display("FAIL reset err_timeout got %b want 0", bus0.err_timeout);
    end
    if (bus0.frame_cnt !== 8'd0) begin
      n_bad++; $display("FAIL reset frame_cnt got %0d want 0", bus0.frame_cnt);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset in_ready got %b/%b want 1", bus0.in_ready, bus1.in_ready);
    end
  endtask

  task automatic test_identity();
    bit done;
    core_mode = 0; core_lat = 3; core_gap = 1'b0;
    for (int k = 0; k < 16; k++) begin xr[k] = W'(k); xi[k] = W'(15 - k); end
    run_frame(1'b0, 0, -1, done);
    if (done) exp_frames++;
    n_cmp += 3;
    if (!done) begin n_bad++; $display("FAIL identity frame done got 0 want 1"); end
    if (cx.size() != 16 || (cx_last - cx_first) != 15) begin
      n_bad++; $display("FAIL identity core_x span got %0d/%0d want 16/15", cx.size(),
                        cx_last - cx_first);
    end
    if (rdy_viol != 0) begin n_bad++; $display("FAIL identity in_ready got %0d want 0", rdy_viol); end
    if (done && cx.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        n_cmp++;
        if (cx[k] !== W'(k)) begin n_bad++; $display("FAIL identity core_x[%0d] got %0d want %0d", k, cx[k], k); end
      end
      for (int k = 0; k < 16; k++) begin
        n_cmp += 2;
        if (o0[k] !== exp_out(0, k)) begin n_bad++; $display("FAIL identity out0[%0d] got %h want %h", k, o0[k], exp_out(0, k)); end
        if (o1[k] !== exp_out(1, k)) begin n_bad++; $display("FAIL identity out1[%0d] got %h want %h", k, o1[k], exp_out(1, k)); end
      end
    end
    n_cmp += 2;
    if (bus0.frame_cnt !== 8'(exp_frames) || bus1.frame_cnt !== 8'(exp_frames)) begin
      n_bad++; $display("FAIL identity frame_cnt got %0d/%0d want %0d", bus0.frame_cnt, bus1.frame_cnt, exp_frames);
    end
    if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0) begin
      n_bad++; $display("FAIL identity busy got %b/%b want 0", bus0.busy, bus1.busy);
    end
  endtask

  task automatic test_bitrev();
    bit done;
    core_mode = 1; core_lat = 3; core_gap = 1'b0;
    for (int k = 0; k < 16; k++) begin xr[k] = W'($urandom); xi[k] = W'($urandom); end
    run_frame(1'b0, 0, -1, done);
    if (done) exp_frames++;
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL bitrev frame done got 0 want 1"); end
    if (done) begin
      for (int k = 0; k < 16; k++) begin
        n_cmp += 3;
        if (o1[k][2*W-1:W] !== W'(rev_tbl[k])) begin
          n_bad++; $display("FAIL bitrev order[%0d] got %0d want %0d", k, o1[k][2*W-1:W], rev_tbl[k]);
        end
        if (o1[k] !== exp_out(1, k)) begin n_bad++; $display("FAIL bitrev out1[%0d] got %h want %h", k, o1[k], exp_out(1, k)); end
        if (o0[k] !== exp_out(0, k)) begin n_bad++; $display("FAIL bitrev out0[%0d] got %h want %h", k, o0[k], exp_out(0, k)); end
      end
    end
    n_cmp++;
    if (bus1.frame_cnt !== 8'(exp_frames)) begin
      n_bad++; $display("FAIL bitrev frame_cnt got %0d want %0d", bus1.frame_cnt, exp_frames);
    end
  endtask

  task automatic test_backpressure();
    bit done;
    core_mode = 0; core_lat = 3; core_gap = 1'b0;
    for (int k = 0; k < 16; k++) begin xr[k] = W'($urandom); xi[k] = W'($urandom); end
    run_frame(1'b0, 1, -1, done);
    if (done) exp_frames++;
    n_cmp += 3;
    if (!done) begin n_bad++; $display("FAIL backpressure frame done got 0 want 1"); end
    if (stab_viol != 0) begin n_bad++; $display("FAIL backpressure stall stability got %0d want 0", stab_viol); end
    if (rdy_viol != 0) begin n_bad++; $display("FAIL backpressure in_ready got %0d want 0", rdy_viol); end
    if (done) begin
      for (int k = 0; k < 16; k++) begin
        n_cmp += 2;
        if (o0[k] !== exp_out(0, k)) begin n_bad++; $display("FAIL backpressure out0[%0d] got %h want %h", k, o0[k], exp_out(0, k)); end
        if (o1[k] !== exp_out(1, k)) begin n_bad++; $display("FAIL backpressure out1[%0d] got %h want %h", k, o1[k], exp_out(1, k)); end
      end
    end
    n_cmp++;
    if (bus0.frame_cnt !== 8'(exp_frames)) begin
      n_bad++; $display("FAIL backpressure frame_cnt got %0d want %0d", bus0.frame_cnt, exp_frames);
    end
  endtask

  task automatic test_timeout();
    bit ok, done;
    int n;
    core_mode = 2; core_gap = 1'b0;
    for (int k = 0; k < 16; k++) begin xr[k] = W'($urandom); xi[k] = W'($urandom); end
    feed_frame(1'b0, ok);
    n = 0;
    do begin @(negedge clk); drive_in(1'b0, '0, '0); n++; end while (!bus0.core_x_valid && n < 50);
    do begin @(negedge clk); n++; end while (bus0.core_x_valid && n < 100);
    // Now one negedge past the edge that ended the feed.
    n = 0;
    while (!bus0.err_timeout && n < 200) begin @(negedge clk); n++; end
    exp_err = 1'b1;
    n_cmp += 5;
    if (!ok) begin n_bad++; $display("FAIL timeout feed accepted got 0 want 1"); end
    if (n != TO) begin n_bad++; $display("FAIL timeout err delay got %0d want %0d", n, TO); end
    if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL timeout in_ready got %b/%b want 1", bus0.in_ready, bus1.in_ready);
    end
    if (bus1.err_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout err1 got %b want 1", bus1.err_timeout); end
    if (bus0.frame_cnt !== 8'(exp_frames) || bus0.busy !== 1'b0) begin
      n_bad++; $display("FAIL timeout frame_cnt/busy got %0d/%b want %0d/0", bus0.frame_cnt, bus0.busy, exp_frames);
    end
    core_mode = 0; core_lat = 3;
    for (int k = 0; k < 16; k++) begin xr[k] = W'($urandom); xi[k] = W'($urandom); end
    run_frame(1'b0, 2, -1, done);
    if (done) exp_frames++;
    n_cmp += 3;
    if (!done) begin n_bad++; $display("FAIL timeout recovery done got 0 want 1"); end
    if (bus0.err_timeout !== exp_err) begin n_bad++; $display("FAIL timeout sticky got %b want %b", bus0.err_timeout, exp_err); end
    if (bus0.frame_cnt !== 8'(exp_frames)) begin
      n_bad++; $display("FAIL timeout recovery frame_cnt got %0d want %0d", bus0.frame_cnt, exp_frames);
    end
    if (done) begin
      for (int k = 0; k < 16; k++) begin
        n_cmp += 2;
        if (o0[k] !== exp_out(0, k)) begin n_bad++; $display("FAIL timeout out0[%0d] got %h want %h", k, o0[k], exp_out(0, k)); end
        if (o1[k] !== exp_out(1, k)) begin n_bad++; $display("FAIL timeout out1[%0d] got %h want %h", k, o1[k], exp_out(1, k)); end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    bit done;
    core_mode = 0; core_lat = 3; core_gap = 1'b0;
    for (int k = 0; k < 16; k++) begin xr[k] = W'($urandom); xi[k] = W'($urandom); end
    run_frame(1'b0, 0, 7, done);
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL midreset reached sample 7 got 0 want 1"); end
    reset_n = 1'b0;
    #1;
    exp_frames = 0; exp_err = 1'b0;
    n_cmp += 4;
    if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0 || bus0.out_last !== 1'b0) begin
      n_bad++; $display("FAIL midreset out_valid/last got %b/%b/%b want 0", bus0.out_valid, bus1.out_valid, bus0.out_last);
    end
    if (bus0.out_real !== '0 || bus1.out_imag !== '0) begin
      n_bad++; $display("FAIL midreset out data got %h/%h want 0", bus0.out_real, bus1.out_imag);
    end
    if (bus0.busy !== 1'b0 || bus0.err_timeout !== 1'b0 || bus1.err_timeout !== 1'b0) begin
      n_bad++; $display("FAIL midreset busy/err got %b/%b/%b want 0", bus0.busy, bus0.err_timeout, bus1.err_timeout);
    end
    if (bus0.frame_cnt !== 8'd0 || bus1.frame_cnt !== 8'd0) begin
      n_bad++; $display("FAIL midreset frame_cnt got %0d/%0d want 0", bus0.frame_cnt, bus1.frame_cnt);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 16; k++) begin xr[k] = W'($urandom); xi[k] = W'($urandom); end
    run_frame(1'b0, 0, -1, done);
    if (done) exp_frames++;
    n_cmp += 2;
    if (!done) begin n_bad++; $display("FAIL midreset next frame done got 0 want 1"); end
    if (bus0.frame_cnt !== 8'(exp_frames)) begin
      n_bad++; $display("FAIL midreset frame_cnt got %0d want %0d", bus0.frame_cnt, exp_frames);
    end
    if (done) begin
      for (int k = 0; k < 16; k++) begin
        n_cmp += 2;
        if (o0[k] !== exp_out(0, k)) begin n_bad++; $display("FAIL midreset out0[%0d] got %h want %h", k, o0[k], exp_out(0, k)); end
        if (o1[k] !== exp_out(1, k)) begin n_bad++; $display("FAIL midreset out1[%0d] got %h want %h", k, o1[k], exp_out(1, k)); end
      end
    end
  endtask

  task automatic test_gaps();
    bit done;
    core_mode = 0; core_lat = 20; core_gap = 1'b1;
    for (int k = 0; k < 16; k++) begin xr[k] = W'($urandom); xi[k] = W'($urandom); end
    run_frame(1'b1, 2, -1, done);
    if (done) exp_frames++;
    n_cmp += 4;
    if (!done) begin n_bad++; $display("FAIL gaps frame done got 0 want 1"); end
    if (bus0.err_timeout !== 1'b0 || bus1.err_timeout !== 1'b0) begin
      n_bad++; $display("FAIL gaps watchdog got %b/%b want 0", bus0.err_timeout, bus1.err_timeout);
    end
    if (stab_viol != 0) begin n_bad++; $display("FAIL gaps stall stability got %0d want 0", stab_viol); end
    if (bus0.frame_cnt !== 8'(exp_frames)) begin
      n_bad++; $display("FAIL gaps frame_cnt got %0d want %0d", bus0.frame_cnt, exp_frames);
    end
    if (done) begin
      for (int k = 0; k < 16; k++) begin
        n_cmp += 2;
        if (o0[k] !== exp_out(0, k)) begin n_bad++; $display("FAIL gaps out0[%0d] got %h want %h", k, o0[k], exp_out(0, k)); end
        if (o1[k] !== exp_out(1, k)) begin n_bad++; $display("FAIL gaps out1[%0d] got %h want %h", k, o1[k], exp_out(1, k)); end
      end
    end
    core_gap = 1'b0; core_lat = 3;
  endtask

  initial begin
    drive_in(1'b0, '0, '0);
    bus0.out_ready = 1'b1; bus1.out_ready = 1'b1;
    bus0.core_y_valid = 1'b0; bus0.core_y_real = '0; bus0.core_y_imag = '0;
    bus1.core_y_valid = 1'b0; bus1.core_y_real = '0; bus1.core_y_imag = '0;
    test_reset();
    test_identity();
    test_bitrev();
    test_backpressure();
    test_timeout();
    test_reset_mid_drain();
    test_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end
endmodule
